// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane writes, right-aligned reads after a fixed
// latency, with a one-cycle ack and access-error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_read,
    input  logic [3:0]  where2write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] load_data,
    output logic        data_ack,
    output logic        access_err,
    output logic        busy
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BYTES = 33'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] load_data_q, load_data_d;

    logic [31:0] mem [DEPTH];

    logic          wr_req, in_range, mask_ok, mem_we;
    logic [AW-1:0] idx;
    logic [31:0]   word_rd, shifted;

    function automatic logic legal_mask(input logic [3:0] m);
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100, 4'b1111: legal_mask = 1'b1;
            default:                             legal_mask = 1'b0;
        endcase
    endfunction

    assign wr_req   = |where2write;
    assign in_range = {1'b0, data_addr} < BYTES;
    assign mask_ok  = legal_mask(where2write);
    assign idx      = data_addr[AW+1:2];
    assign word_rd  = mem[idx];
    assign shifted  = in_range ? (word_rd >> {data_addr[1:0], 3'b000}) : '0;
    // Gated by rst_n so a write presented during reset never lands.
    assign mem_we   = rst_n && (state_q == IDLE) && wr_req && in_range && mask_ok;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (where2write[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    err_d   = !(in_range && mask_ok);
                    state_d = WR_ACK;
                end else if (data_read) begin
                    err_d = !in_range;
                    cnt_d = 4'(READ_LAT - 1);
                    if (READ_LAT == 1) begin
                        load_data_d = shifted;
                        state_d     = RD_RESP;
                    end else begin
                        rd_data_d = shifted;
                        state_d   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    load_data_d = rd_data_q;
                    state_d     = RD_RESP;
                end
            end
            WR_ACK:  state_d = IDLE;
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            load_data_q <= load_data_d;
        end
    end

    assign load_data  = load_data_q;
    assign data_ack   = (state_q == WR_ACK) || (state_q == RD_RESP);
    assign access_err = data_ack && err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH=1024, READ_LAT=2).
module tb_data_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_read;
    logic [3:0]  where2write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] load_data;
    logic        data_ack;
    logic        access_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH(1024), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_read  (data_read),
        .where2write(where2write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .load_data  (load_data),
        .data_ack   (data_ack),
        .access_err (access_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges from acceptance until data_ack is seen; bounded at 20.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!data_ack && n < 20);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] data, input logic exp_err);
        int n;
        where2write = mask;
        data_addr   = addr;
        data_in     = data;
        wait_ack(n);
        chk({tag, "_lat"}, 32'(n), 32'd1);
        chk({tag, "_err"}, {31'd0, access_err}, {31'd0, exp_err});
        @(posedge clk);
        #1 where2write = 4'h0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp, input logic exp_err);
        int n;
        data_read = 1'b1;
        data_addr = addr;
        wait_ack(n);
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_err"}, {31'd0, access_err}, {31'd0, exp_err});
        @(posedge clk);
        #1 data_read = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        rst_n = 1'b0;
        data_read = 1'b0;
        where2write = 4'h0;
        data_addr = '0;
        data_in = '0;
        #1;
        chk("rst_load", load_data, 32'h0);
        chk("rst_ack", {31'd0, data_ack}, 32'd0);
        chk("rst_err", {31'd0, access_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_write("sw10", 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
        do_read("rd10", 32'h10, 32'hDEADBEEF, 1'b0);

        do_write("sb13", 32'h13, 4'b1000, 32'h5A000000, 1'b0);
        chk("hold_after_wr", load_data, 32'hDEADBEEF);
        do_read("rd13", 32'h13, 32'h0000005A, 1'b0);
        do_read("rd10b", 32'h10, 32'h5AADBEEF, 1'b0);
        do_read("rd11", 32'h11, 32'h005AADBE, 1'b0);

        do_write("sw20", 32'h20, 4'b1111, 32'h11112222, 1'b0);
        do_write("sh22", 32'h22, 4'b1100, 32'h12340000, 1'b0);
        do_read("rd22", 32'h22, 32'h00001234, 1'b0);
        do_read("rd20", 32'h20, 32'h12342222, 1'b0);
        do_write("badmask", 32'h20, 4'b0101, 32'hFFFFFFFF, 1'b1);
        do_read("rd20b", 32'h20, 32'h12342222, 1'b0);
        do_write("sh21", 32'h21, 4'b0110, 32'h00ABCD00, 1'b0);
        do_read("rd21", 32'h21, 32'h0012ABCD, 1'b0);

        do_write("sw0", 32'h0, 4'b1111, 32'h01020304, 1'b0);
        do_write("swlast", 32'hFFC, 4'b1111, 32'h77665544, 1'b0);
        do_read("rdoor", 32'h1000, 32'h0, 1'b1);
        do_write("wroor", 32'h1000, 4'b1111, 32'hBAD0BAD0, 1'b1);
        do_read("rd0", 32'h0, 32'h01020304, 1'b0);
        do_read("rdlast", 32'hFFC, 32'h77665544, 1'b0);
        do_read("rdhigh", 32'hFFFFFFFC, 32'h0, 1'b1);

        // Write and read together: write first, then the held read.
        data_read   = 1'b1;
        where2write = 4'b1111;
        data_addr   = 32'h30;
        data_in     = 32'hCAFEF00D;
        wait_ack(n);
        chk("both_wr_lat", 32'(n), 32'd1);
        chk("both_wr_err", {31'd0, access_err}, 32'd0);
        @(posedge clk);
        #1 where2write = 4'h0;
        wait_ack(n);
        chk("both_rd_lat", 32'(n), 32'(LAT));
        chk("both_rd_data", load_data, 32'hCAFEF00D);
        @(posedge clk);
        #1 data_read = 1'b0;
        @(negedge clk);
        chk("both_no_extra", {31'd0, data_ack}, 32'd0);

        // Requests while busy are ignored.
        do_write("sw40", 32'h40, 4'b1111, 32'h11223344, 1'b0);
        do_write("sw44", 32'h44, 4'b1111, 32'h55667788, 1'b0);
        data_read = 1'b1;
        data_addr = 32'h40;
        @(posedge clk);
        #1;
        where2write = 4'b1111;
        data_addr   = 32'h44;
        data_in     = 32'hFFFFFFFF;
        @(negedge clk);
        chk("busy_wait_ack", {31'd0, data_ack}, 32'd0);
        chk("busy_flag", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("busy_resp_ack", {31'd0, data_ack}, 32'd1);
        chk("busy_resp_data", load_data, 32'h11223344);
        #1;
        where2write = 4'h0;
        data_read   = 1'b0;
        @(negedge clk);
        chk("busy_after_ack", {31'd0, data_ack}, 32'd0);
        chk("busy_after_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        do_read("rd44", 32'h44, 32'h55667788, 1'b0);

        // Reset during RD_WAIT discards the read.
        do_write("sw50", 32'h50, 4'b1111, 32'hA5A5A5A5, 1'b0);
        data_read = 1'b1;
        data_addr = 32'h50;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        data_read = 1'b0;
        #1;
        chk("mid_rst_load", load_data, 32'h0);
        chk("mid_rst_ack", {31'd0, data_ack}, 32'd0);
        chk("mid_rst_err", {31'd0, access_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_ack) acks++;
        end
        chk("mid_rst_no_ack", 32'(acks), 32'd0);
        @(posedge clk);
        #1;
        do_read("rd50", 32'h50, 32'hA5A5A5A5, 1'b0);
        do_read("rd10c", 32'h10, 32'h5AADBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-cycle RISC-V core; the memory-side end of the load/store interface.
- Accepts the byte-lane write mask and lane-positioned store data produced by the core's store formatter.
- Serves read strobes by returning the addressed word right-aligned, so that the core's load extender always finds the target byte/half in bits [7:0]/[15:0].
- Adds a fixed-latency read pipeline, an ack handshake and access-error reporting.

Parameters:
- DEPTH, 1024, number of 32-bit words in storage; byte range 0 .. 4*DEPTH-1.
- READ_LAT, 2, cycles from read acceptance to data_ack; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_read  in  1  read request, held by the core until data_ack.
- where2write  in  4  byte-lane write mask; nonzero means write request, held until data_ack.
- data_addr  in  32  byte address.
- data_in  in  32  store data, already placed in its byte lanes.
- load_data  out  32  read result, right-aligned by data_addr[1:0].
- data_ack  out  1  one-cycle completion pulse for read or write.
- access_err  out  1  pulses together with data_ack when the access was rejected.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; load_data=0, data_ack=0, access_err=0, busy=0, latency counter=0.
  - Storage array is not cleared.
- States are IDLE, WR_ACK, RD_WAIT, RD_RESP.
- IDLE, write has priority:
  - If where2write!=0 (regardless of data_read), the access is checked and committed at this same edge.
  - Each lane i with mask bit i set takes data_in[8i+7:8i] at word data_addr[31:2]. Other lanes are unchanged.
  - Next state is WR_ACK.
- IDLE, read:
  - If where2write==0 and data_read=1, latch data_addr and load counter=READ_LAT-1.
  - If READ_LAT=1, go directly to RD_RESP; otherwise go to RD_WAIT.
- RD_WAIT: decrement counter each cycle; when counter reaches 1, go to RD_RESP.
- RD_RESP:
  - Drives load_data = word >> (8*addr[1:0]), zero-filled in the top.
  - data_ack=1; returns to IDLE.
- Latency: data_ack rises exactly READ_LAT cycles after the accepting edge.
- load_data holds its value until the next read response. It is unaffected by writes and by rejected reads (rejected reads set load_data=0).
- WR_ACK: data_ack=1 for one cycle; returns to IDLE.
- Inputs are ignored in every non-IDLE state, including the ack cycle. The core must deassert or change its request on the edge where it samples data_ack=1.
- Read-after-write to the same word returns the newly written bytes. The array read happens at read acceptance, after the write has committed.
- Error, out of range: data_addr >= 4*DEPTH gives access_err=1 with data_ack.
  - Write: no storage change.
  - Read: load_data=0.
- Error, illegal write mask: legal masks are 0001, 0010, 0100, 1000, 0011, 0110, 1100 and 1111.
  - Any other nonzero mask gives access_err=1 with data_ack and no storage change.
  - There is no alignment check on data_addr[1:0] beyond the mask legality check.
- busy = (state != IDLE).
- Reset mid-operation:
  - A pending read is discarded; no ack is issued.
  - A write is atomic: it has either committed at its accepting edge or not occurred at all.

Test Plan:
- Reset, then sw: addr 0x10, mask 1111, data 0xDEADBEEF. Then read 0x10 → ack 2 cycles after accept, load_data=0xDEADBEEF, access_err=0.
- sb: addr 0x13, mask 1000, data_in 0x5A000000, onto the word above. Then read 0x13 → load_data=0x0000005A; read 0x10 → 0x5AADBEEF.
- sh: addr 0x22, mask 1100, data 0x12340000. Then read 0x22 → 0x00001234. Also write mask 0101 to 0x20 → access_err=1, word at 0x20 unchanged.
- Read at address 4*DEPTH → data_ack with access_err=1, load_data=0. A write to the same address leaves no trace on later in-range reads.
- Write and read asserted simultaneously (0x30, 0xCAFEF00D) → write serviced first with ack after 1 cycle. The held read then returns 0xCAFEF00D. Requests presented while busy=1 produce no extra ack.
- rst_n pulsed low during RD_WAIT → data_ack never asserts, outputs are 0. The next read after release behaves normally and storage is intact.
